// File: rtl/preg_handshake_pkg.sv
// preg_handshake_pkg: shared pipeline-stage types, payload structs and defaults.
package preg_handshake_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  // Execute-to-memory payload; callers cast it to DATA_WIDTH.
  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] addr;
    logic [21:0] rsvd;
  } ex_mem_t;
endpackage

// File: rtl/preg_handshake.sv
// preg_handshake: valid/ready pipeline-stage register with flush and optional skid entry.
module preg_handshake
  import preg_handshake_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int SKID_EN        = 1,
  parameter int CLEAR_ON_FLUSH = 0
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_skid_full
);
  logic w_acc;
  logic w_dlv;
  assign w_acc = i_valid & o_ready;
  assign w_dlv = o_valid & i_ready;
  generate
    if (SKID_EN != 0) begin : g_skid
      state_t r_state, w_state_nxt;
      logic [DATA_WIDTH-1:0] r_main, r_skid;
      logic w_load_main, w_load_skid, w_promote;
      assign o_ready     = r_state != SKID;
      assign o_valid     = r_state != EMPTY;
      assign o_skid_full = r_state == SKID;
      assign o_data      = r_main;
      always_ff @(posedge i_clk or negedge i_arstn)
        if (!i_arstn) r_state <= EMPTY;
        else r_state <= w_state_nxt;
      always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_promote   = 1'b0;
        if (i_flush) w_state_nxt = EMPTY;
        else
          case (r_state)
            EMPTY: if (w_acc) begin
              w_state_nxt = FULL;
              w_load_main = 1'b1;
            end
            FULL: if (w_acc && w_dlv) w_load_main = 1'b1;
              else if (w_acc) begin
                w_state_nxt = SKID;
                w_load_skid = 1'b1;
              end else if (w_dlv) w_state_nxt = EMPTY;
            SKID: if (w_dlv) begin
              w_state_nxt = FULL;
              w_promote   = 1'b1;
            end
            default: w_state_nxt = EMPTY;
          endcase
      end
      // Loads are already suppressed under flush; only the optional clear remains.
      always_ff @(posedge i_clk or negedge i_arstn)
        if (!i_arstn) begin
          r_main <= '0;
          r_skid <= '0;
        end else if (CLEAR_ON_FLUSH != 0 && i_flush) begin
          r_main <= '0;
          r_skid <= '0;
        end else begin
          if (w_load_main) r_main <= i_data;
          else if (w_promote) r_main <= r_skid;
          if (w_load_skid) r_skid <= i_data;
        end
    end else begin : g_pass
      logic r_valid;
      logic [DATA_WIDTH-1:0] r_main;
      assign o_ready     = i_ready | ~r_valid;
      assign o_valid     = r_valid;
      assign o_skid_full = 1'b0;
      assign o_data      = r_main;
      always_ff @(posedge i_clk or negedge i_arstn)
        if (!i_arstn) begin
          r_valid <= 1'b0;
          r_main  <= '0;
        end else begin
          r_valid <= i_flush ? 1'b0 : w_acc ? 1'b1 : w_dlv ? 1'b0 : r_valid;
          if (CLEAR_ON_FLUSH != 0 && i_flush) r_main <= '0;
          else if (w_acc && !i_flush) r_main <= i_data;
        end
    end
  endgenerate
endmodule

// File: tb/tb_preg_handshake.sv
// tb_preg_handshake: three configurations driven in lockstep against a queue model.
module tb_preg_handshake;
  logic clk = 1'b0;
  logic arstn, valid, rdy, flush;
  logic [63:0] din;
  logic [2:0] d_rdy, d_val, d_skid;
  logic [63:0] d_data [3];
  int n_chk = 0;
  int n_fail = 0;
  int cnt [3] = '{0, 0, 0};
  logic [63:0] mem [3][2];

  always #5 clk = ~clk;

  // d0: skid, stale flush; d1: skid, clearing flush; d2: single entry
  for (genvar g = 0; g < 3; g++) begin : g_dut
    preg_handshake #(.DATA_WIDTH(64), .SKID_EN(g < 2 ? 1 : 0), .CLEAR_ON_FLUSH(g == 1 ? 1 : 0)) u_dut (
      .i_clk(clk), .i_arstn(arstn), .i_valid(valid), .o_ready(d_rdy[g]), .i_data(din),
      .i_flush(flush), .o_valid(d_val[g]), .i_ready(rdy), .o_data(d_data[g]), .o_skid_full(d_skid[g]));
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_ready(int k);
    return (k == 2) ? (rdy || cnt[k] == 0) : (cnt[k] < 2);
  endfunction

  always @(posedge clk or negedge arstn) begin
    for (int k = 0; k < 3; k++) begin
      int c;
      logic [63:0] a0, a1;
      bit acc, dlv;
      c = cnt[k];
      a0 = mem[k][0];
      a1 = mem[k][1];
      acc = valid && m_ready(k);
      dlv = (c > 0) && rdy;
      if (!arstn || flush) c = 0;
      else begin
        if (dlv) begin
          a0 = a1;
          c--;
        end
        if (acc) begin
          if (c == 0) a0 = din;
          else a1 = din;
          c++;
        end
      end
      cnt[k] <= c;
      mem[k][0] <= a0;
      mem[k][1] <= a1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_valid", k), 64'(d_val[k]), 64'(cnt[k] > 0));
      chk($sformatf("d%0d_ready", k), 64'(d_rdy[k]), 64'(m_ready(k)));
      chk($sformatf("d%0d_skid", k), 64'(d_skid[k]), 64'(k < 2 && cnt[k] == 2));
      if (cnt[k] > 0) chk($sformatf("d%0d_data", k), d_data[k], mem[k][0]);
    end
  end

  task automatic step(logic v, logic [63:0] d, logic r, logic f);
    valid = v;
    din = d;
    rdy = r;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arstn = 1'b0;
    valid = 1'b0;
    din = '0;
    rdy = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 64'(d_val[k]), 64'd0);
      chk("rst_ready", 64'(d_rdy[k]), 64'd1);
      chk("rst_data", d_data[k], 64'd0);
    end
    arstn = 1'b1;
    step(1, 64'hAA, 0, 0);
    for (int k = 0; k < 3; k++) chk("hold_aa", d_data[k], 64'hAA);
    #2 arstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_valid", 64'(d_val[k]), 64'd0);
      chk("midrst_data", d_data[k], 64'd0);
      chk("midrst_ready", 64'(d_rdy[k]), 64'd1);
      chk("midrst_skid", 64'(d_skid[k]), 64'd0);
    end
    @(posedge clk);
    #1 arstn = 1'b1;
    step(1, 64'h11, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("first_valid", 64'(d_val[k]), 64'd1);
      chk("first_data", d_data[k], 64'h11);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1, 64'(i), 1, 0);
      for (int k = 0; k < 3; k++) begin
        chk("stream_data", d_data[k], 64'(i));
        chk("stream_ready", 64'(d_rdy[k]), 64'd1);
      end
    end
    step(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) chk("drain_valid", 64'(d_val[k]), 64'd0);
    step(1, 64'h10, 0, 0);
    step(1, 64'h20, 0, 0);
    chk("bp_skid", 64'(d_skid[0]), 64'd1);
    chk("bp_ready", 64'(d_rdy[0]), 64'd0);
    chk("bp_data", d_data[0], 64'h10);
    chk("bp_pass_data", d_data[2], 64'h10);
    step(0, 0, 1, 0);
    chk("bp_data2", d_data[0], 64'h20);
    chk("bp_ready2", 64'(d_rdy[0]), 64'd1);
    chk("bp_skid2", 64'(d_skid[0]), 64'd0);
    step(0, 0, 1, 0);
    chk("bp_empty", 64'(d_val[0]), 64'd0);
    step(1, 64'h30, 0, 0);
    step(1, 64'h40, 0, 0);
    chk("fl_pre_skid", 64'(d_skid[1]), 64'd1);
    step(1, 64'h50, 0, 1);
    for (int k = 0; k < 3; k++) begin
      chk("fl_valid", 64'(d_val[k]), 64'd0);
      chk("fl_skid", 64'(d_skid[k]), 64'd0);
      chk("fl_ready", 64'(d_rdy[k]), 64'd1);
    end
    chk("fl_clear_data", d_data[1], 64'd0);
    chk("fl_stale_data", d_data[0], 64'h30);
    step(1, 64'h77, 0, 0);
    chk("pt_ready_lo", 64'(d_rdy[2]), 64'd0);
    chk("pt_hold", d_data[2], 64'h77);
    valid = 1'b1;
    din = 64'h88;
    rdy = 1'b1;
    #1;
    chk("pt_ready_comb", 64'(d_rdy[2]), 64'd1);
    @(posedge clk);
    #1;
    chk("pt_data", d_data[2], 64'h88);
    repeat (10000)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 2));
    repeat (3) step(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) chk("end_empty", 64'(d_val[k]), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
